// File: rtl/alu_mc.sv
// Registered ALU with valid/ready handshake; ops 11..13 (mul/div/rem) run iteratively.
// Optional iterative multiply/divide datapath is built only when ALU_MC_MULDIV_EN is defined.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [3:0]       alu_pattern,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  localparam int SHW = $clog2(WIDTH);

  // Handshake: an input transfer happens on in_valid && in_ready, an output transfer on
  // out_valid && out_ready; alu_out is held while out_valid && !out_ready.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [WIDTH-1:0] single_res;
  logic [SHW-1:0]   sh;
  logic signed [WIDTH-1:0] b_signed;
  logic             accept, take, is_iter;

  assign sh          = data_a[SHW-1:0];
  assign b_signed    = data_b;
  assign in_ready    = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign out_valid   = (state_q == DONE);
  assign alu_out     = alu_out_q;
  assign dbg_state_o = state_q;
  assign accept      = in_valid && in_ready;
  assign take        = out_valid && out_ready;

  always_comb begin
    single_res = '0;
    case (alu_pattern)
      4'd0:    single_res = data_a;
      4'd1:    single_res = data_a + data_b;
      4'd2:    single_res = data_a & data_b;
      4'd3:    single_res = data_a | data_b;
      4'd4:    single_res = data_b << sh;
      4'd5:    single_res = data_b >> sh;
      4'd6:    single_res = data_a - data_b;
      4'd7:    single_res = b_signed >>> sh;
      4'd8:    single_res = {{(WIDTH-1){1'b0}}, $signed(data_a) < $signed(data_b)};
      4'd9:    single_res = ~(data_a | data_b);
      4'd10:   single_res = {{(WIDTH-1){1'b0}}, $signed(data_a) > $signed(data_b)};
      4'd14:   single_res = {{(WIDTH-1){1'b0}}, data_a < data_b};
      default: single_res = '0;
    endcase
  end

`ifdef ALU_MC_MULDIV_EN
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] mul_acc, div_rem, div_quo;
  logic             div_ge;

  assign is_iter = (alu_pattern == 4'd11) || (alu_pattern == 4'd12) || (alu_pattern == 4'd13);
  assign busy    = (state_q == BUSY);

  // Mul: acc accumulates a (shifted left) whenever b's LSB is set. Div: acc is the partial
  // remainder and a shifts the dividend out while the quotient bits shift in.
  assign mul_acc = acc_q + (b_q[0] ? a_q : '0);
  assign div_ge  = {acc_q, a_q[WIDTH-1]} >= {1'b0, b_q};
  assign div_rem = div_ge ? ({acc_q[WIDTH-2:0], a_q[WIDTH-1]} - b_q)
                          : {acc_q[WIDTH-2:0], a_q[WIDTH-1]};
  assign div_quo = {a_q[WIDTH-2:0], div_ge};
`else
  assign is_iter = 1'b0;
  assign busy    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept)    state_d = is_iter ? BUSY : DONE;
        else if (take) state_d = IDLE;
      end
`ifdef ALU_MC_MULDIV_EN
      BUSY:    if (cnt_q == '0) state_d = DONE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_out_d = alu_out_q;
    if (accept && !is_iter) alu_out_d = single_res;
`ifdef ALU_MC_MULDIV_EN
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (accept && is_iter) begin
      op_d  = alu_pattern;
      a_d   = data_a;
      b_d   = data_b;
      acc_d = '0;
      cnt_d = SHW'(WIDTH - 1);
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - SHW'(1);
      if (op_q == 4'd11) begin
        acc_d = mul_acc;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
      end else begin
        acc_d = div_rem;
        a_d   = div_quo;
      end
      if (cnt_q == '0)
        alu_out_d = (op_q == 4'd11) ? mul_acc : (op_q == 4'd12) ? div_quo : div_rem;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      alu_out_q <= '0;
`ifdef ALU_MC_MULDIV_EN
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      alu_out_q <= alu_out_d;
`ifdef ALU_MC_MULDIV_EN
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc (WIDTH=32): op table, latency, backpressure,
// back-to-back throughput and mid-operation reset.
module tb_alu_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_a;
  logic [W-1:0] data_b;
  logic [3:0]   alu_pattern;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_out;
  logic         busy;
  logic [1:0]   dbg_state_o;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  alu_mc #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_a      (data_a),
    .data_b      (data_b),
    .alu_pattern (alu_pattern),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_out     (alu_out),
    .busy        (busy),
    .dbg_state_o (dbg_state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op with out_ready=1, then wait (bounded) for the result and check value and latency.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    int bad;
    @(negedge clk);
    in_valid = 1'b1; alu_pattern = op; data_a = a; data_b = b;
    #1 check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; data_a = ~a; data_b = ~b;
    lat = 1;
    bad = 0;
    while (!out_valid && lat < 200) begin
      if (!busy || in_ready) bad++;
      @(negedge clk);
      lat++;
    end
    check(tag, alu_out, exp);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (exp_lat > 1) check({tag, "_busy"}, 32'(bad), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int bad;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    data_a = '0; data_b = '0; alu_pattern = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_alu_out", alu_out, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_state", 32'(dbg_state_o), 32'd0);

    run_op("add_wrap", 4'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 1);
    run_op("sub_wrap", 4'd6, 32'd3, 32'd5, 32'hFFFF_FFFE, 1);
    run_op("pass_a", 4'd0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 1);
    run_op("and", 4'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1);
    run_op("or", 4'd3, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1);
    run_op("nor", 4'd9, 32'h0000_F0F0, 32'h0000_FF00, 32'hFFFF_000F, 1);
    run_op("sra", 4'd7, 32'd4, 32'h8000_0000, 32'hF800_0000, 1);
    run_op("srl", 4'd5, 32'd4, 32'h8000_0000, 32'h0800_0000, 1);
    run_op("sll", 4'd4, 32'd36, 32'd1, 32'h0000_0010, 1);
    run_op("slt_t", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_op("slt_f", 4'd8, 32'd5, 32'hFFFF_FFFD, 32'd0, 1);
    run_op("sltu", 4'd14, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run_op("sgt", 4'd10, 32'd1, 32'hFFFF_FFFF, 32'd1, 1);
    run_op("zero15", 4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1);

`ifdef ALU_MC_MULDIV_EN
    run_op("mul", 4'd11, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 33);
    run_op("div", 4'd12, 32'd100, 32'd7, 32'd14, 33);
    run_op("rem", 4'd13, 32'd100, 32'd7, 32'd2, 33);
    run_op("div0", 4'd12, 32'd123, 32'd0, 32'hFFFF_FFFF, 33);
    run_op("rem0", 4'd13, 32'd9, 32'd0, 32'd9, 33);
`else
    run_op("mul_off", 4'd11, 32'h0001_0000, 32'h0001_0001, 32'd0, 1);
    run_op("div_off", 4'd12, 32'd100, 32'd7, 32'd0, 1);
    run_op("rem_off", 4'd13, 32'd100, 32'd7, 32'd0, 1);
`endif

    // Backpressure: result held for 5 cycles while a second op waits on in_valid.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; alu_pattern = 4'd1; data_a = 32'd10; data_b = 32'd20;
    @(negedge clk);
    data_a = 32'd1; data_b = 32'd1;
    check("bp_first", alu_out, 32'd30);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || alu_out !== 32'd30 || in_ready !== 1'b0) bad++;
    end
    check("bp_stable", 32'(bad), 32'd0);
    out_ready = 1'b1;
    #1 check("bp_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_second", alu_out, 32'd2);
    @(negedge clk);
    check("bp_drained", 32'(out_valid), 32'd0);

    // Back-to-back: 10 op-1 transfers must yield 10 results on consecutive cycles.
    got = 0;
    bad = 0;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got++;
        if (exp_q.size() == 0) bad++;
        else check("b2b_data", alu_out, exp_q.pop_front());
      end
      if (i < 10) begin
        in_valid = 1'b1; alu_pattern = 4'd1;
        data_a = 32'h1111_1111 * i; data_b = 32'(i + 7);
        exp_q.push_back(32'h1111_1111 * i + 32'(i + 7));
      end else begin
        in_valid = 1'b0;
      end
    end
    check("b2b_count", 32'(got), 32'd10);
    check("b2b_left", 32'(exp_q.size() + bad), 32'd0);

    // Reset while an op is in flight (iterative) or its result is held (single-cycle build).
    @(negedge clk);
`ifdef ALU_MC_MULDIV_EN
    in_valid = 1'b1; alu_pattern = 4'd12; data_a = 32'd100; data_b = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("midop_busy", 32'(busy), 32'd1);
`else
    out_ready = 1'b0; in_valid = 1'b1; alu_pattern = 4'd1; data_a = 32'd40; data_b = 32'd2;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midop_held", alu_out, 32'd42);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    check("midrst_state", 32'(dbg_state_o), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_alu_out", alu_out, 32'd0);
    repeat (40) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("midrst_no_result", 32'(bad), 32'd0);
    run_op("post_rst_add", 4'd1, 32'd5, 32'd6, 32'd11, 1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, registered successor to the core's single-cycle ALU.
- Keeps the existing 4-bit op encoding 0..10 and adds unsigned compare, multiply and iterative divide/remainder.
- Sits between the decode/register-read stage and writeback. Uses a valid/ready handshake so the pipeline can stall on multi-cycle ops.
- Single-cycle ops have 1-cycle latency; mul/div/rem run iteratively.

Parameters:
- WIDTH, 32, datapath width in bits; must be ≥ 8 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridable.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operands and op are valid this cycle
- in_ready  out  1  block can accept an op this cycle
- data_a  in  WIDTH  operand A
- data_b  in  WIDTH  operand B
- alu_pattern  in  4  op select
- out_valid  out  1  alu_out holds a result
- out_ready  in  1  consumer takes the result this cycle
- alu_out  out  WIDTH  result, held stable while out_valid && !out_ready
- busy  out  1  iterative op in progress

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, alu_out=0, busy=0, cycle counter=0. in_ready=1 in the first cycle after reset.
- Reset asserted mid-operation aborts the op immediately; no result is produced.
- Op encoding (A=data_a, B=data_b, sh=A[SHW-1:0]):
  - 0 → A
  - 1 → A+B
  - 2 → A&B
  - 3 → A|B
  - 4 → B<<sh
  - 5 → B>>sh (logical)
  - 6 → A−B
  - 7 → B>>>sh (arithmetic)
  - 8 → signed A<B ? 1 : 0
  - 9 → ~(A|B)
  - 10 → signed A>B ? 1 : 0
  - 11 → low WIDTH bits of A*B
  - 12 → unsigned A/B
  - 13 → unsigned A%B
  - 14 → unsigned A<B ? 1 : 0
  - 15 → 0
- Add, sub and mul wrap modulo 2^WIDTH; no overflow flag.
- States: IDLE, BUSY, DONE.
- Transfer rules:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
- IDLE:
  - Transfer with op ≠ 11..13 → DONE next cycle, result registered. Latency 1.
  - Transfer with op 11..13 → BUSY. Operands and op are latched; counter=WIDTH-1.
- BUSY:
  - Mul: one shift-add step per cycle.
  - Div/rem: one restoring-division step per cycle.
  - busy=1; counter decrements each cycle. At counter==0 → DONE. Result is visible WIDTH+1 cycles after acceptance.
  - in_ready=0. in_valid is ignored and must be held by the producer.
- DONE:
  - out_valid=1; alu_out holds the value until out_ready.
  - Output transfer with no new input → IDLE, out_valid=0.
  - Output transfer plus a simultaneous input transfer → the new op is processed as from IDLE. Back-to-back single-cycle ops sustain 1 result per cycle.
- Divide by zero (B=0):
  - Op 12 → all-ones; op 13 → A.
  - Still takes the full WIDTH+1 cycles (constant latency).
- Operand changes on data_a/data_b while BUSY have no effect, because the operands were latched at acceptance.
- alu_out must not change while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: ALU_MC_MULDIV_EN.
- Defined: ops 11–13 behave as above, and the BUSY state and iterative datapath are built.
- Undefined:
  - The BUSY path and mul/div logic are not synthesised.
  - Ops 11–13 complete in 1 cycle with result 0, like op 15.
  - busy is tied to 0.

Test Plan:
- Reset, then WIDTH=32, op 1, A=0xFFFFFFFF, B=2, out_ready=1 → next cycle out_valid=1, alu_out=0x00000001. Then op 6, A=3, B=5 → 0xFFFFFFFE.
- Shifts: op 7, A=4, B=0x80000000 → 0xF8000000. Op 5 with the same operands → 0x08000000. Op 4, A=36 (sh=4), B=1 → 0x10.
- Compare: op 8, A=0xFFFFFFFF, B=1 → 1. Op 14 with the same operands → 0. Op 10, A=1, B=0xFFFFFFFF → 1.
- Mul/div (macro defined):
  - Op 11, A=0x10000, B=0x10001 → 0x00010000. out_valid asserts exactly 33 cycles after acceptance; busy=1 and in_ready=0 throughout.
  - Op 12, A=100, B=7 → 14; op 13 with the same operands → 2.
  - Op 12, B=0 → 0xFFFFFFFF; op 13, A=9, B=0 → 9.
- Backpressure and throughput:
  - Hold out_ready=0 for 5 cycles after a result → alu_out and out_valid stay stable and in_ready=0. Then out_ready=1 → one transfer.
  - 10 back-to-back op 1 transfers with out_ready=1 → 10 results on consecutive cycles.
- Reset mid-op: assert rst 10 cycles into op 12 → next cycle IDLE, out_valid=0, busy=0. A following op 1 completes normally.
